// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// opcodes, FSM state codes, ALU operation classes and datapath mux selects.
package multicycle_pkg;

    // Opcode field values (6-bit MIPS primary opcode)
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    // ALU operation classes seen by the ALU controller
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_SLTI  = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_ORI   = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       not_equal;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       signed_imm;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Purely combinational Moore output map: FSM state and latched opcode to the
// datapath control word. FETCH alone also looks at mem_ready to gate IR/PC writes.
module ctrl_out_decode
    import multicycle_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] i_state,
    input  logic [OP_W-1:0]    i_op_q,
    input  logic               i_op_illegal,
    input  logic               i_mem_ready,
    output logic [CTRL_W-1:0]  o_ctrl
);

    ctrl_t      w_ctrl;
    logic [2:0] w_imm_alu_op;
    logic       w_imm_signed;

    // IEXEC and IWB share this so the ALU class and extension mode stay stable
    // across both cycles of an immediate-ALU instruction.
    always_comb begin
        w_imm_alu_op = ALU_ADDI;
        w_imm_signed = 1'b1;
        if (i_op_q == OP_W'(OP_SLTI)) begin
            w_imm_alu_op = ALU_SLTI;
        end else if (i_op_q == OP_W'(OP_LUI)) begin
            w_imm_alu_op = ALU_LUI;
        end else if (i_op_q == OP_W'(OP_ORI)) begin
            w_imm_alu_op = ALU_ORI;
            w_imm_signed = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a
        // bit unassigned, which would otherwise infer a latch.
        w_ctrl            = '0;
        w_ctrl.signed_imm = 1'b1;
        w_ctrl.alu_op     = ALU_ADD;

        case (i_state)
            STATE_W'(S_FETCH): begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = i_mem_ready;
                w_ctrl.pc_write  = i_mem_ready;
            end
            STATE_W'(S_DECODE): begin
                w_ctrl.alu_src_b = SRCB_IMM_SH2;
                w_ctrl.illegal   = i_op_illegal;
            end
            STATE_W'(S_MEMADR): begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMRD): begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            STATE_W'(S_MEMWB): begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            STATE_W'(S_REXEC): begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_RT;
                w_ctrl.alu_op    = ALU_RTYPE;
            end
            STATE_W'(S_RWB): begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            STATE_W'(S_BRANCH): begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_RT;
                w_ctrl.alu_op        = ALU_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_ctrl.not_equal     = (i_op_q == OP_W'(OP_BNE));
            end
            STATE_W'(S_JUMP): begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_JUMP;
            end
            STATE_W'(S_IEXEC): begin
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.alu_op     = w_imm_alu_op;
                w_ctrl.signed_imm = w_imm_signed;
            end
            STATE_W'(S_IWB): begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_op     = w_imm_alu_op;
                w_ctrl.signed_imm = w_imm_signed;
            end
            default: begin
                // Unused codes drive no strobes; the FSM leaves them next clock.
            end
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back over a shared ALU and a single memory port.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               Not_equal_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic               Signed_o,
    output logic [1:0]         PCSource_o,
    output logic               Illegal_o
);

    logic [STATE_W-1:0] r_state;
    logic [OP_W-1:0]    r_op_q;
    logic [STATE_W-1:0] w_state_nxt;
    logic               w_op_illegal;
    logic [CTRL_W-1:0]  w_ctrl_bits;
    ctrl_t              w_ctrl;

    // DECODE dispatches on the live IR opcode because op_q only captures it at
    // the end of DECODE; every later state uses op_q.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_illegal = 1'b0;

        case (r_state)
            STATE_W'(S_FETCH): begin
                if (mem_ready_i) w_state_nxt = STATE_W'(S_DECODE);
            end
            STATE_W'(S_DECODE): begin
                case (instr_op_i)
                    OP_W'(OP_LW), OP_W'(OP_SW):    w_state_nxt = STATE_W'(S_MEMADR);
                    OP_W'(OP_R):                   w_state_nxt = STATE_W'(S_REXEC);
                    OP_W'(OP_BEQ), OP_W'(OP_BNE):  w_state_nxt = STATE_W'(S_BRANCH);
                    OP_W'(OP_J):                   w_state_nxt = STATE_W'(S_JUMP);
                    OP_W'(OP_ADDI), OP_W'(OP_SLTI),
                    OP_W'(OP_ORI), OP_W'(OP_LUI):  w_state_nxt = STATE_W'(S_IEXEC);
                    default: begin
                        w_state_nxt  = STATE_W'(S_FETCH);
                        w_op_illegal = 1'b1;
                    end
                endcase
            end
            STATE_W'(S_MEMADR): begin
                w_state_nxt = (r_op_q == OP_W'(OP_LW)) ? STATE_W'(S_MEMRD)
                                                        : STATE_W'(S_MEMWR);
            end
            STATE_W'(S_MEMRD): begin
                if (mem_ready_i) w_state_nxt = STATE_W'(S_MEMWB);
            end
            STATE_W'(S_MEMWR): begin
                if (mem_ready_i) w_state_nxt = STATE_W'(S_FETCH);
            end
            STATE_W'(S_REXEC): w_state_nxt = STATE_W'(S_RWB);
            STATE_W'(S_IEXEC): w_state_nxt = STATE_W'(S_IWB);
            STATE_W'(S_MEMWB), STATE_W'(S_RWB), STATE_W'(S_BRANCH),
            STATE_W'(S_JUMP), STATE_W'(S_IWB): w_state_nxt = STATE_W'(S_FETCH);
            default: w_state_nxt = STATE_W'(S_FETCH);
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= STATE_W'(S_FETCH);
            r_op_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == STATE_W'(S_DECODE)) r_op_q <= instr_op_i;
        end
    end

    ctrl_out_decode #(
        .OP_W    (OP_W),
        .STATE_W (STATE_W)
    ) u_out_decode (
        .i_state      (r_state),
        .i_op_q       (r_op_q),
        .i_op_illegal (w_op_illegal),
        .i_mem_ready  (mem_ready_i),
        .o_ctrl       (w_ctrl_bits)
    );

    assign w_ctrl = ctrl_t'(w_ctrl_bits);

    assign PCWrite_o     = w_ctrl.pc_write;
    assign PCWriteCond_o = w_ctrl.pc_write_cond;
    assign Not_equal_o   = w_ctrl.not_equal;
    assign IorD_o        = w_ctrl.iord;
    assign MemRead_o     = w_ctrl.mem_read;
    assign MemWrite_o    = w_ctrl.mem_write;
    assign IRWrite_o     = w_ctrl.ir_write;
    assign MemtoReg_o    = w_ctrl.mem_to_reg;
    assign RegWrite_o    = w_ctrl.reg_write;
    assign RegDst_o      = w_ctrl.reg_dst;
    assign ALUSrcA_o     = w_ctrl.alu_src_a;
    assign ALUSrcB_o     = w_ctrl.alu_src_b;
    assign ALU_op_o      = ALUOP_W'(w_ctrl.alu_op);
    assign Signed_o      = w_ctrl.signed_imm;
    assign PCSource_o    = w_ctrl.pc_source;
    assign Illegal_o     = w_ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a cycle-by-cycle vector table for
// each instruction class plus a hand-written asynchronous reset sequence.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_SLTI = 6'b001010;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_LUI  = 6'b001111;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BAD  = 6'b111111;
    localparam logic [5:0] T_JAL  = 6'b000011;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       mem_ready_i;
    logic       PCWrite_o, PCWriteCond_o, Not_equal_o, IorD_o, MemRead_o, MemWrite_o;
    logic       IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, Signed_o, Illegal_o;
    logic [1:0] ALUSrcB_o, PCSource_o;
    logic [2:0] ALU_op_o;
    logic [19:0] w_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl #(.OP_W(6), .ALUOP_W(3), .STATE_W(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_op_i    (instr_op_i),
        .mem_ready_i   (mem_ready_i),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .Not_equal_o   (Not_equal_o),
        .IorD_o        (IorD_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IRWrite_o     (IRWrite_o),
        .MemtoReg_o    (MemtoReg_o),
        .RegWrite_o    (RegWrite_o),
        .RegDst_o      (RegDst_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .ALU_op_o      (ALU_op_o),
        .Signed_o      (Signed_o),
        .PCSource_o    (PCSource_o),
        .Illegal_o     (Illegal_o)
    );

    assign w_out = {PCWrite_o, PCWriteCond_o, Not_equal_o, IorD_o, MemRead_o, MemWrite_o,
                    IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o,
                    ALU_op_o, Signed_o, PCSource_o, Illegal_o};

    function automatic logic [19:0] mk(
        input logic pcw, pcwc, ne, iord, mr, mw, irw, m2r, rw, rdst, sa,
        input logic [1:0] sb, input logic [2:0] aop, input logic sg,
        input logic [1:0] ps, input logic ill);
        return {pcw, pcwc, ne, iord, mr, mw, irw, m2r, rw, rdst, sa, sb, aop, sg, ps, ill};
    endfunction

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [19:0] exp);
        vec_t v;
        v.tag = tag; v.op = op; v.rdy = rdy; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic [5:0] op, input logic rdy);
        @(posedge clk_i);
        #1;
        instr_op_i  = op;
        mem_ready_i = rdy;
        #4;
    endtask

    logic [19:0] e_fetch, e_fetch_wait, e_decode, e_decode_ill, e_memadr, e_memrd, e_memwb;
    logic [19:0] e_memwr, e_rexec, e_rwb, e_br_ne, e_br_eq, e_jump;
    logic [19:0] e_iexec_addi, e_iwb_addi, e_iexec_ori, e_iwb_ori;
    logic [19:0] e_iexec_slti, e_iwb_slti, e_iexec_lui, e_iwb_lui;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                  pcw pcwc ne iord mr mw irw m2r rw rdst sa  sb     aop    sg  ps   ill
        e_fetch      = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 1, 2'b00, 0);
        e_fetch_wait = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 1, 2'b00, 0);
        e_decode     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 1, 2'b00, 0);
        e_decode_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 1, 2'b00, 1);
        e_memadr     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 1, 2'b00, 0);
        e_memrd      = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00, 0);
        e_memwb      = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 1, 2'b00, 0);
        e_memwr      = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00, 0);
        e_rexec      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 1, 2'b00, 0);
        e_rwb        = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 1, 2'b00, 0);
        e_br_ne      = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 1, 2'b01, 0);
        e_br_eq      = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 1, 2'b01, 0);
        e_jump       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b10, 0);
        e_iexec_addi = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 1, 2'b00, 0);
        e_iwb_addi   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b100, 1, 2'b00, 0);
        e_iexec_ori  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b111, 0, 2'b00, 0);
        e_iwb_ori    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b111, 0, 2'b00, 0);
        e_iexec_slti = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b101, 1, 2'b00, 0);
        e_iwb_slti   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b101, 1, 2'b00, 0);
        e_iexec_lui  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b110, 1, 2'b00, 0);
        e_iwb_lui    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b110, 1, 2'b00, 0);

        // Opcode input is scrambled after DECODE to prove later states use op_q.
        add("addi fetch",  T_BAD,  1, 4'd0,  e_fetch);
        add("addi decode", T_ADDI, 1, 4'd1,  e_decode);
        add("addi iexec",  T_BAD,  1, 4'd10, e_iexec_addi);
        add("addi iwb",    T_ORI,  1, 4'd11, e_iwb_addi);
        add("lw fetch",    T_R,    1, 4'd0,  e_fetch);
        add("lw decode",   T_LW,   1, 4'd1,  e_decode);
        add("lw memadr",   T_SW,   1, 4'd2,  e_memadr);
        add("lw memrd w1", T_SW,   0, 4'd3,  e_memrd);
        add("lw memrd w2", T_SW,   0, 4'd3,  e_memrd);
        add("lw memrd rd", T_SW,   1, 4'd3,  e_memrd);
        add("lw memwb",    T_SW,   1, 4'd4,  e_memwb);
        add("sw fetch w",  T_R,    0, 4'd0,  e_fetch_wait);
        add("sw fetch",    T_R,    1, 4'd0,  e_fetch);
        add("sw decode",   T_SW,   1, 4'd1,  e_decode);
        add("sw memadr",   T_LW,   1, 4'd2,  e_memadr);
        add("sw memwr w",  T_LW,   0, 4'd5,  e_memwr);
        add("sw memwr",    T_LW,   1, 4'd5,  e_memwr);
        add("r fetch",     T_BAD,  1, 4'd0,  e_fetch);
        add("r decode",    T_R,    1, 4'd1,  e_decode);
        add("r rexec",     T_BAD,  1, 4'd6,  e_rexec);
        add("r rwb",       T_BAD,  1, 4'd7,  e_rwb);
        add("bne fetch",   T_R,    1, 4'd0,  e_fetch);
        add("bne decode",  T_BNE,  1, 4'd1,  e_decode);
        add("bne branch",  T_BEQ,  1, 4'd8,  e_br_ne);
        add("beq fetch",   T_R,    1, 4'd0,  e_fetch);
        add("beq decode",  T_BEQ,  1, 4'd1,  e_decode);
        add("beq branch",  T_BNE,  1, 4'd8,  e_br_eq);
        add("j fetch",     T_R,    1, 4'd0,  e_fetch);
        add("j decode",    T_J,    1, 4'd1,  e_decode);
        add("j jump",      T_BAD,  1, 4'd9,  e_jump);
        add("ori fetch",   T_R,    1, 4'd0,  e_fetch);
        add("ori decode",  T_ORI,  1, 4'd1,  e_decode);
        add("ori iexec",   T_ADDI, 1, 4'd10, e_iexec_ori);
        add("ori iwb",     T_ADDI, 1, 4'd11, e_iwb_ori);
        add("slti fetch",  T_R,    1, 4'd0,  e_fetch);
        add("slti decode", T_SLTI, 1, 4'd1,  e_decode);
        add("slti iexec",  T_ORI,  1, 4'd10, e_iexec_slti);
        add("slti iwb",    T_ORI,  1, 4'd11, e_iwb_slti);
        add("lui fetch",   T_R,    1, 4'd0,  e_fetch);
        add("lui decode",  T_LUI,  1, 4'd1,  e_decode);
        add("lui iexec",   T_ORI,  1, 4'd10, e_iexec_lui);
        add("lui iwb",     T_ORI,  1, 4'd11, e_iwb_lui);
        add("ill fetch",   T_R,    1, 4'd0,  e_fetch);
        add("ill decode",  T_BAD,  1, 4'd1,  e_decode_ill);
        add("ill back",    T_BAD,  1, 4'd0,  e_fetch);
        add("jal decode",  T_JAL,  1, 4'd1,  e_decode_ill);
        add("jal back",    T_R,    0, 4'd0,  e_fetch_wait);

        rst_i       = 1'b0;
        instr_op_i  = T_R;
        mem_ready_i = 1'b1;
        #3;
        check("reset state", 32'(dut.r_state), 32'd0);
        check("reset outs",  32'(w_out), 32'(e_fetch));
        check("reset op_q",  32'(dut.r_op_q), 32'd0);
        mem_ready_i = 1'b0;
        #9;
        rst_i = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].rdy);
            check({vecs[i].tag, " state"}, 32'(dut.r_state), 32'(vecs[i].st));
            check({vecs[i].tag, " outs"},  32'(w_out), 32'(vecs[i].exp));
        end

        // Asynchronous reset in the middle of a stalled SW write.
        drive(T_R, 1);
        check("rst-sw fetch", 32'(dut.r_state), 32'd0);
        drive(T_SW, 1);
        check("rst-sw decode", 32'(dut.r_state), 32'd1);
        drive(T_ADDI, 1);
        check("rst-sw memadr", 32'(dut.r_state), 32'd2);
        drive(T_ADDI, 0);
        check("rst-sw memwr state", 32'(dut.r_state), 32'd5);
        check("rst-sw memwr strobe", 32'(MemWrite_o), 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst-sw memwrite drop", 32'(MemWrite_o), 32'd0);
        check("rst-sw state fetch", 32'(dut.r_state), 32'd0);
        check("rst-sw memread", 32'(MemRead_o), 32'd1);
        check("rst-sw alusrcb", 32'(ALUSrcB_o), 32'b01);
        check("rst-sw op_q clear", 32'(dut.r_op_q), 32'd0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        drive(T_SW, 0);
        check("post-rst wait state", 32'(dut.r_state), 32'd0);
        check("post-rst wait outs", 32'(w_out), 32'(e_fetch_wait));
        drive(T_SW, 1);
        check("post-rst fetch outs", 32'(w_out), 32'(e_fetch));
        drive(T_R, 1);
        check("post-rst decode", 32'(dut.r_state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the next-generation MIPS-subset CPU.
- Replaces the single-cycle combinational decoder with a Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles.
- Shares one ALU and one memory port per instruction.
- Adds LW/SW/J support and a memory-ready handshake; parametrised in opcode and ALU-op width.

Parameters:
- OP_W, 6, opcode field width.
- ALUOP_W, 3, width of ALU_op_o to the ALU controller (must be >=3).
- STATE_W, 4, state register width (must hold 12 states).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- instr_op_i  in  OP_W  opcode from instruction register
- mem_ready_i  in  1  memory completes current access this cycle
- PCWrite_o  out  1  unconditional PC write
- PCWriteCond_o  out  1  PC write if branch condition true
- Not_equal_o  out  1  branch condition is "not equal" (BNE)
- IorD_o  out  1  0=PC addresses memory, 1=ALUOut
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  load instruction register
- MemtoReg_o  out  1  write-back source, 1=MDR
- RegWrite_o  out  1  register file write
- RegDst_o  out  1  1=rd, 0=rt
- ALUSrcA_o  out  1  0=PC, 1=rs
- ALUSrcB_o  out  2  00=rt, 01=const 4, 10=sign/zero-ext imm, 11=ext imm<<2
- ALU_op_o  out  ALUOP_W  ALU operation class
- Signed_o  out  1  1=sign-extend immediate, 0=zero-extend (ORI)
- PCSource_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
- Illegal_o  out  1  one-cycle pulse in DECODE on an unknown opcode

Behaviour:
- Opcodes:
  - R=000000, J=000010, BEQ=000100, BNE=000101, ADDI=001000, SLTI=001010, ORI=001101, LUI=001111, LW=100011, SW=101011.
- States (encoding):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11.
- Reset:
  - On rst_i low, state goes to FETCH asynchronously, op_q clears to 0, and all outputs take their FETCH values.
  - Reset mid-instruction aborts it. No write strobe is asserted after reset until the next legal write state.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000 (add).
  - IRWrite=1 and PCWrite=1 only when mem_ready_i=1.
  - Holds in FETCH while mem_ready_i=0; on mem_ready_i=1, goes to DECODE.
- DECODE:
  - Latches instr_op_i into op_q.
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALU_op=000 (branch target).
  - Next state: LW/SW→MEMADR; R→REXEC; BEQ/BNE→BRANCH; J→JUMP; ADDI/SLTI/ORI/LUI→IEXEC.
  - Any other opcode: Illegal_o=1 for one cycle, then FETCH.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALU_op=000, Signed=1.
  - Next: →MEMRD if op_q=LW, else →MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Waits for mem_ready_i, then →MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next: →FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Waits for mem_ready_i, then →FETCH.
  - MemWrite stays asserted through the wait.
- REXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALU_op=010.
  - Next: →RWB.
- RWB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next: →FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALU_op=001, PCWriteCond=1, PCSource=01, Not_equal=(op_q==BNE).
  - Next: →FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=10.
  - Next: →FETCH.
- IEXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=10.
  - ALU_op: ADDI=100, SLTI=101, LUI=110, ORI=111.
  - Signed=0 for ORI, 1 otherwise.
- IWB:
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0.
  - ALU_op and Signed are held from IEXEC.
  - Next: →FETCH.
- Default values:
  - Any output not listed for a state is 0.
  - Exceptions: Signed=1 and ALU_op=000 by default.
  - ALU_op is zero-extended to ALUOP_W.
- Latency, counted with mem_ready_i=1 in the first cycle of each memory wait:
  - J and BEQ/BNE: 3 cycles.
  - R-type and I-ALU: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each cycle of mem_ready_i=0 adds one cycle.
- Output timing:
  - All outputs are Moore, decoded from state and op_q only.
  - The single exception is the mem_ready_i gating of IRWrite/PCWrite in FETCH.
- Unreachable state codes 12..15 recover to FETCH on the next clock.

Decomposition:
- Package multicycle_pkg holds:
  - Opcode localparams.
  - State encodings.
  - ALU_op class constants (000/001/010/100/101/110/111).
  - ALUSrcB and PCSource select constants.
- One natural sub-module, ctrl_out_decode: a purely combinational map from state and op_q to the output word.
- The top level keeps the state register, op_q, and the next-state logic.

Test Plan:
- ADDI (001000), mem_ready_i=1:
  - States FETCH, DECODE, IEXEC, IWB, then FETCH.
  - RegWrite=1 only in cycle 4; ALU_op=100 in cycles 3–4; Signed=1.
- LW (100011), mem_ready_i low 2 cycles in MEMRD:
  - MEMRD held 3 cycles with MemRead=1, IorD=1.
  - Then MEMWB with RegWrite=1, MemtoReg=1; total 7 cycles.
- BNE (000101):
  - In BRANCH: PCWriteCond=1, Not_equal=1, PCSource=01, ALU_op=001.
  - BEQ gives the same outputs with Not_equal=0.
- ORI (001101):
  - Signed=0 in IEXEC/IWB; ALU_op=111.
- Illegal opcode 111111:
  - Illegal_o=1 in DECODE for 1 cycle, then FETCH.
  - No RegWrite or MemWrite is asserted.
- rst_i driven low asynchronously during MEMWR (SW):
  - MemWrite drops to 0 immediately and state=FETCH.
  - After release, FETCH outputs apply (MemRead=1, ALUSrcB=01).
